// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for bcd_to_bin: digit-set request on the input side,
// converted value plus status flags on the output side.
interface bcd_to_bin_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 11
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIGITS*4-1:0]   d_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      value;
  logic                  overflow;
  logic                  bad_digit;

  // Converter side
  modport slave (
    input  in_valid, d_in, out_ready,
    output in_ready, out_valid, value, overflow, bad_digit
  );

  // Digit source / result consumer side
  modport master (
    output in_valid, d_in, out_ready,
    input  in_ready, out_valid, value, overflow, bad_digit
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter: one acc*10+digit step per clock,
// most significant digit first. Flags nibbles > 9 and results that do not
// fit in OUT_W bits.
// Build option BCD_TO_BIN_SAT_EN: overflowed results saturate to 2^OUT_W-1;
// without it the result is the true decimal value mod 2^OUT_W.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 11
) (
  input  logic         clock,
  input  logic         reset,
  bcd_to_bin_if.slave  bus
);

  localparam int DW    = DIGITS * 4;
  localparam int MIN_W = $clog2(10 ** DIGITS);
  // Wide enough for one clamped step (sat) or the full decimal value (wrap)
  localparam int ACC_W = (OUT_W + 4 > MIN_W) ? OUT_W + 4 : MIN_W;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [ACC_W-1:0] MAXV  = ACC_W'((1 << OUT_W) - 1);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [DW-1:0]    dig_q;     // shifts left so the next digit is always on top
  logic [ACC_W-1:0] acc_q;
  logic [IDX_W-1:0] idx_q;
  logic             bad_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] value_q;
  logic             overflow_q;
  logic             bad_digit_q;

  logic [DIGITS-1:0] nib_bad;
  logic [3:0]        cur_dig;
  logic [ACC_W-1:0]  acc_mul;
  logic [ACC_W-1:0]  acc_nxt;
  logic              acc_big;
  logic              ovf_nxt;
  logic [OUT_W-1:0]  res_value;

  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    assign nib_bad[g] = (bus.d_in[g*4 +: 4] > 4'd9);
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.value     = value_q;
  assign bus.overflow  = overflow_q;
  assign bus.bad_digit = bad_digit_q;
  assign cur_dig       = dig_q[DW-1 -: 4];

  // One accumulate step plus the result that the final step would publish
  always_comb begin
    acc_mul = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, cur_dig};
    acc_big = (acc_mul > MAXV);
    ovf_nxt = ovf_q | acc_big;
`ifdef BCD_TO_BIN_SAT_EN
    // Clamp to 2^OUT_W so the accumulator can never wrap
    acc_nxt = acc_big ? (MAXV + 1'b1) : acc_mul;
`else
    acc_nxt = acc_mul;
`endif
    res_value = acc_nxt[OUT_W-1:0];
`ifdef BCD_TO_BIN_SAT_EN
    if (ovf_nxt) res_value = {OUT_W{1'b1}};
`endif
    if (bad_q) res_value = '0;
  end

  // Control FSM, accumulator and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      dig_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      value_q     <= '0;
      overflow_q  <= 1'b0;
      bad_digit_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            dig_q <= bus.d_in;
            bad_q <= |nib_bad;
            acc_q <= '0;
            ovf_q <= 1'b0;
            idx_q <= '0;
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_nxt;
          ovf_q <= ovf_nxt;
          dig_q <= dig_q << 4;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
            value_q     <= res_value;
            overflow_q  <= ovf_nxt & ~bad_q;
            bad_digit_q <= bad_q;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: expected results are queued on accept
// and compared by a monitor on each output handshake.
module tb_bcd_to_bin;

  typedef struct packed {
    logic [15:0] d;
    logic [10:0] v;
    logic        o;
    logic        b;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  bcd_to_bin_if #(.DIGITS(4), .OUT_W(11)) bus ();

  bcd_to_bin #(.DIGITS(4), .OUT_W(11)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic [15:0] d);
    exp_t e;
    int   dec;
    int   n;
    bit   bad;
    dec = 0;
    bad = 0;
    for (int i = 3; i >= 0; i--) begin
      n = int'(d[i*4 +: 4]);
      if (n > 9) bad = 1;
      dec = dec * 10 + n;
    end
    e.d = d;
    e.o = 1'b0;
    e.b = 1'b0;
    if (bad) begin
      e.v = '0;
      e.b = 1'b1;
    end else if (dec > 2047) begin
      e.o = 1'b1;
`ifdef BCD_TO_BIN_SAT_EN
      e.v = 11'd2047;
`else
      e.v = 11'(dec % 2048);
`endif
    end else begin
      e.v = 11'(dec);
    end
    return e;
  endfunction

  // Output monitor: a handshake completes on the next rising edge
  always @(negedge clock) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got value=%0d ovf=%0b bad=%0b, required no output",
                 bus.value, bus.overflow, bus.bad_digit);
      end else begin
        e = sb.pop_front();
        if (bus.value !== e.v || bus.overflow !== e.o || bus.bad_digit !== e.b) begin
          errors++;
          $display("FAIL result_%h: got value=%0d ovf=%0b bad=%0b, required value=%0d ovf=%0b bad=%0b",
                   e.d, bus.value, bus.overflow, bus.bad_digit, e.v, e.o, e.b);
        end
      end
    end
  end

  // Present d and wait for the accept edge; returns just after that edge
  task automatic send(input logic [15:0] d, input bit hold);
    bit ok;
    ok = 0;
    bus.d_in     = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.in_ready === 1'b1) begin
        @(posedge clock);
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout_%h: got in_ready never high, required accept", d);
    end else begin
      sb.push_back(model(d));
    end
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.d_in      = '0;
    bus.out_ready = 1'b1;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.value !== 11'd0 ||
        bus.overflow !== 1'b0 || bus.bad_digit !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b val=%0d ovf=%b bad=%b, required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.value, bus.overflow, bus.bad_digit);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    send(16'h1234, 0);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_ready: got %b, required 0", bus.in_ready);
    end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL latency: got %0d edges, required 4", lat);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_handshake: got vld=%b rdy=%b, required vld=0 rdy=1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_values();
    logic [15:0] vals [5];
    vals = '{16'h2047, 16'h2048, 16'h12A4, 16'h9999, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      send(vals[i], 0);
      drain();
    end
  endtask

  task automatic test_backpressure();
    bit   seen;
    exp_t e;
    bus.out_ready = 1'b0;
    send(16'h0042, 0);
    e    = model(16'h0042);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (bus.out_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_valid_timeout: got out_valid=0, required 1");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.value !== e.v ||
          bus.overflow !== 1'b0 || bus.bad_digit !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b val=%0d ovf=%b bad=%b, required 1 0 %0d 0 0",
                 i, bus.out_valid, bus.in_ready, bus.value, bus.overflow, bus.bad_digit, e.v);
      end
      @(posedge clock);
      #1;
      bus.d_in     = 16'h0999;
      bus.in_valid = (i % 2 == 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got out_valid=%b, required 0", bus.out_valid);
    end
    repeat (8) @(posedge clock);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_ghost: got rdy=%b pending=%0d, required rdy=1 pending=0",
               bus.in_ready, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    send(16'h0500, 0);
    void'(sb.pop_back());   // this conversion is aborted
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.value !== 11'd0 || bus.in_ready !== 1'b1 ||
        bus.overflow !== 1'b0 || bus.bad_digit !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b val=%0d rdy=%b ovf=%b bad=%b, required 0 0 1 0 0",
               bus.out_valid, bus.value, bus.in_ready, bus.overflow, bus.bad_digit);
    end
    #1;
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_partial: got out_valid=%b, required 0", bus.out_valid);
    end
    send(16'h0007, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    vals = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(vals[i], (i != 3));
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
